// File: rtl/bsg_mcl_rcv_slot_arbiter_pkg.sv
// Shared widths and defaults for the manycore-link receive slot arbiter.
// The default packet length is the mc fifo width split into AXIL words.
package bsg_mcl_rcv_slot_arbiter_pkg;

    localparam int mc_fifo_width_lp = 128;
    localparam int axil_width_lp    = 32;
    localparam int words_per_pkt_lp = mc_fifo_width_lp / axil_width_lp;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_mcl_rcv_slot_arbiter_if.sv
// Slot-side and host-side signals of the receive slot arbiter.
// The arbiter uses the slave modport; the driver of slots/consumer uses master.
interface bsg_mcl_rcv_slot_arbiter_if
    import bsg_mcl_rcv_slot_arbiter_pkg::*;
#(
    parameter int num_slots_p = 4,
    parameter int width_p     = 32,
    parameter int idx_w_p     = safe_clog2(num_slots_p)
) ();

    logic [num_slots_p-1:0]         v_i;
    logic [num_slots_p*width_p-1:0] data_i;
    logic [num_slots_p-1:0]         yumi_o;
    logic [num_slots_p-1:0]         slot_en_i;
    logic                           v_o;
    logic [width_p-1:0]             data_o;
    logic [idx_w_p-1:0]             slot_o;
    logic                           last_o;
    logic                           ready_i;
    logic                           busy_o;

    modport slave (
        input  v_i, data_i, slot_en_i, ready_i,
        output yumi_o, v_o, data_o, slot_o, last_o, busy_o
    );

    modport master (
        output v_i, data_i, slot_en_i, ready_i,
        input  yumi_o, v_o, data_o, slot_o, last_o, busy_o
    );

endinterface

// File: rtl/bsg_mcl_rr_pick.sv
// Round-robin pick: first requester at or after the pointer, wrapping.
// Purely combinational; produces one-hot grant, index and found flag.
module bsg_mcl_rr_pick
    import bsg_mcl_rcv_slot_arbiter_pkg::*;
#(
    parameter int num_p = 4,
    parameter int idx_w_p = safe_clog2(num_p)
) (
    input  logic [num_p-1:0]   req_i,
    input  logic [idx_w_p-1:0] ptr_i,
    output logic [num_p-1:0]   grant_oh_o,
    output logic [idx_w_p-1:0] grant_idx_o,
    output logic               found_o
);

    int j;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found_o     = 1'b0;
        j           = 0;
        for (int k = 0; k < num_p; k++) begin
            j = int'(ptr_i) + k;
            if (j >= num_p) j = j - num_p;
            if (!found_o && req_i[j]) begin
                found_o       = 1'b1;
                grant_idx_o   = idx_w_p'(j);
                grant_oh_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_mcl_rcv_slot_arbiter.sv
// Packet-atomic round-robin arbiter sharing one serial read port
// between the per-slot receive downsizers of the manycore link.
module bsg_mcl_rcv_slot_arbiter
    import bsg_mcl_rcv_slot_arbiter_pkg::*;
#(
    parameter int num_slots_p     = 4,
    parameter int width_p         = 32,
    parameter int words_per_pkt_p = words_per_pkt_lp
) (
    input logic                     clk_i,
    input logic                     reset_i,
    bsg_mcl_rcv_slot_arbiter_if.slave io
);

    localparam int iw_lp = safe_clog2(num_slots_p);
    localparam int cw_lp = safe_clog2(words_per_pkt_p);

    logic             locked_q, locked_d;
    logic [iw_lp-1:0] owner_q, owner_d;
    logic [iw_lp-1:0] ptr_q, ptr_d;
    logic [cw_lp-1:0] cnt_q, cnt_d;

    logic [num_slots_p-1:0] pick_oh;
    logic [num_slots_p-1:0] own_oh;
    logic [iw_lp-1:0]       pick_idx;
    logic                   pick_found;

    logic [iw_lp-1:0] grant_idx;
    logic             has_grant;
    logic             v;
    logic             last;
    logic             xfer;

    bsg_mcl_rr_pick #(
        .num_p(num_slots_p)
    ) u_pick (
        .req_i      (io.v_i & io.slot_en_i),
        .ptr_i      (ptr_q),
        .grant_oh_o (pick_oh),
        .grant_idx_o(pick_idx),
        .found_o    (pick_found)
    );

    // A locked owner keeps the port even when its slot is disabled.
    assign grant_idx = locked_q ? owner_q : pick_idx;
    assign has_grant = locked_q | pick_found;
    assign own_oh    = num_slots_p'(1) << owner_q;

    assign v    = ~reset_i & has_grant & io.v_i[grant_idx];
    assign last = v & (cnt_q == cw_lp'(words_per_pkt_p - 1));
    assign xfer = v & io.ready_i;

    assign io.v_o    = v;
    assign io.last_o = last;
    assign io.busy_o = locked_q & ~reset_i;
    assign io.slot_o = has_grant ? grant_idx : '0;
    assign io.data_o =
        io.data_i[int'(grant_idx)*width_p +: width_p];
    assign io.yumi_o =
        xfer ? (locked_q ? own_oh : pick_oh) : '0;

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            if (last) begin
                cnt_d    = '0;
                locked_d = 1'b0;
                ptr_d    = (grant_idx == iw_lp'(num_slots_p - 1))
                         ? '0 : grant_idx + iw_lp'(1);
            end else begin
                cnt_d    = cnt_q + cw_lp'(1);
                locked_d = 1'b1;
                owner_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
